mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Multicycle controller for the single-issue MIPS-subset CPU. Holds the 3-bit instruction-phase state and computes the next state from the current state and the opcode. Decodes per-phase datapath enables: PC, IR, register file, data memory, mux selects and ALU op. Sits between the instruction register, which supplies `opcode`, and the datapath, which consumes every control output; it also exports `state` for debug and trace.

## Interface
- `CNT_W`, 16 — width of the retired-instruction counter.
- `CLK` input 1 — sole clock, rising edge.
- `RST` input 1 — synchronous, active-high reset.
- `opcode` input 6 — IR[31:26]; valid from ID onward.
- `zero` input 1 — ALU zero flag; sampled in EXE_BR.
- `state` output 3 — current phase.
- `PCWre` output 1 — PC write enable.
- `IRWre` output 1 — IR write enable.
- `RegWre` output 1 — register-file write enable.
- `mRD` output 1 — data-memory read.
- `mWR` output 1 — data-memory write.
- `PCSrc` output 2 — PC mux select: 00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump target.
- `RegDst` output 2 — destination register: 00 = rt, 01 = rd, 10 = $31.
- `ALUSrcB` output 1 — ALU B input: 0 = rt, 1 = extended immediate.
- `DBDataSrc` output 1 — write-back source: 0 = ALU, 1 = memory.
- `WrRegData` output 1 — register write data: 0 = PC+4 (jal), 1 = DB.
- `ExtSel` output 1 — immediate extension: 1 = sign, 0 = zero.
- `ALUOp` output 3 — ALU operation code.
- `halted` output 1 — sticky; set by the halt instruction.
- `illegal` output 1 — sticky; set by an unknown opcode.
- `instr_count` output CNT_W — number of retired instructions.

## Operation
- State encodings: IF = 000, ID = 001, EXE_AL = 110, WB_AL = 111, EXE_BR = 101, EXE_LS = 010, MEM = 011, WB_LD = 100.
- Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, slt 100110, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111.
- State transitions:
  - IF → ID, always.
  - ID → EXE_AL for arithmetic/logic opcodes; EXE_BR for beq; EXE_LS for lw/sw.
  - ID → IF for j/jr/jal. These three complete in ID.
  - ID holds on halt.
  - ID → IF on an unknown opcode (treated as a nop); `illegal` is set.
  - EXE_AL → WB_AL → IF.
  - EXE_BR → IF.
  - EXE_LS → MEM.
  - MEM → IF for sw; MEM → WB_LD for lw.
  - WB_LD → IF.
- Control outputs are combinational from the registered `state` and `opcode`. They are 0 unless listed.
  - IF: `IRWre` = 1.
  - PC update: `PCWre` = 1 in the final state of each instruction (ID for j/jr/jal/unknown, WB_AL, EXE_BR, MEM for sw, WB_LD).
  - jal: `RegWre` = 1, `RegDst` = 10, `WrRegData` = 0 in ID.
  - WB_AL: `RegWre` = 1; `RegDst` = 01 for R-type, 00 for I-type.
  - WB_LD: `RegWre` = 1, `DBDataSrc` = 1.
  - MEM: `mRD` = 1 for lw, `mWR` = 1 for sw.
  - EXE_BR: `PCSrc` = 01 if `zero`, else 00.
  - ID: `PCSrc` = 11 for j/jal, 10 for jr.
  - `ALUSrcB` = 1 for addi, ori, lw, sw.
  - `ExtSel` = 0 for ori only.
  - `ALUOp`: add 000, sub 001, or 011, and 100, slt 110; beq uses sub.
- `instr_count` increments on every edge where `PCWre` = 1. Wraps modulo 2^CNT_W.
- Halt: entering ID with halt sets `halted`. `state` then holds at ID and `PCWre` stays 0 until `RST`.

## Timing
- Reset values on the edge with `RST` = 1: `state` = IF, `halted` = 0, `illegal` = 0, `instr_count` = 0.
- Output values while in the post-reset IF: `IRWre` = 1; all other enables 0; `PCSrc` = 00.
- `RST` overrides everything, including mid-instruction and while halted. The next state after the reset edge is IF, with no write enable asserted in the reset cycle.
- Cycles per instruction: j/jr/jal 2, beq 3, arithmetic 4, sw 4, lw 5.
- `opcode` must be stable from ID through the end of the instruction. `zero` is valid only in EXE_BR.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state encodings;
  - opcode constants;
  - PCSrc, RegDst and ALUOp encodings.
- Sub-module `mc_next_state` is the purely combinational next-state function of `state` and `opcode`.
- The state register, sticky flags, counter and output decode live in `mc_control_unit`.

## Test plan
- Reset: hold `RST` 2 cycles → `state` = 000, `IRWre` = 1, `PCWre` = 0, `instr_count` = 0.
- add (000000): states 000 → 001 → 110 → 111 → 000. In 111: `RegWre` = 1, `RegDst` = 01, `PCWre` = 1. Then `instr_count` = 1.
- lw (110001): 5-cycle trace. In 011: `mRD` = 1. In 100: `RegWre` = 1, `DBDataSrc` = 1. sw (110000): in 011 `mWR` = 1, `PCWre` = 1, then IF.
- beq with `zero` = 1 → `PCSrc` = 01 in 101. With `zero` = 0 → `PCSrc` = 00. Both take 3 cycles.
- jal: in ID `RegWre` = 1, `RegDst` = 10, `PCSrc` = 11, `PCWre` = 1. halt: `halted` = 1, state frozen at 001 for 20 cycles, `instr_count` unchanged.
- Reset mid-instruction: assert `RST` in MEM of lw → next state 000, `mRD` = 0. Unknown opcode 101010: ID → IF, `illegal` = 1, `PCWre` = 1 in ID.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: phase states,
// opcodes, mux-select and ALU operation codes, plus small opcode classifiers.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_e;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [1:0] PCSRC_NEXT   = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_RS     = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    function automatic logic is_rtype(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR) ||
               (op == OP_AND) || (op == OP_SLT);
    endfunction

    function automatic logic is_alu_instr(input logic [5:0] op);
        return is_rtype(op) || (op == OP_ADDI) || (op == OP_ORI);
    endfunction

    function automatic logic is_known(input logic [5:0] op);
        return is_alu_instr(op) || (op == OP_SW) || (op == OP_LW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_JR) ||
               (op == OP_JAL) || (op == OP_HALT);
    endfunction

    function automatic logic [2:0] alu_op_of(input logic [5:0] op);
        case (op)
            OP_SUB, OP_BEQ: return ALU_SUB;
            OP_OR, OP_ORI:  return ALU_OR;
            OP_AND:         return ALU_AND;
            OP_SLT:         return ALU_SLT;
            default:        return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_next_state.sv
// Pure next-phase function of the multicycle controller.
module mc_next_state
    import mc_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [5:0] opcode,
    output state_e     state_next
);

    always_comb begin
        state_next = S_IF;
        case (state)
            S_IF: state_next = S_ID;
            S_ID: begin
                // Jumps and unknown opcodes finish in ID; halt parks here.
                if (is_alu_instr(opcode))
                    state_next = S_EXE_AL;
                else if (opcode == OP_BEQ)
                    state_next = S_EXE_BR;
                else if ((opcode == OP_LW) || (opcode == OP_SW))
                    state_next = S_EXE_LS;
                else if (opcode == OP_HALT)
                    state_next = S_ID;
                else
                    state_next = S_IF;
            end
            S_EXE_AL: state_next = S_WB_AL;
            S_WB_AL:  state_next = S_IF;
            S_EXE_BR: state_next = S_IF;
            S_EXE_LS: state_next = S_MEM;
            S_MEM:    state_next = (opcode == OP_LW) ? S_WB_LD : S_IF;
            S_WB_LD:  state_next = S_IF;
            default:  state_next = S_IF;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle controller: phase register, sticky halt/illegal flags,
// retired-instruction counter and per-phase datapath control decode.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       opcode,
    input  logic             zero,
    output logic [2:0]       state,
    output logic             PCWre,
    output logic             IRWre,
    output logic             RegWre,
    output logic             mRD,
    output logic             mWR,
    output logic [1:0]       PCSrc,
    output logic [1:0]       RegDst,
    output logic             ALUSrcB,
    output logic             DBDataSrc,
    output logic             WrRegData,
    output logic             ExtSel,
    output logic [2:0]       ALUOp,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d, state_next;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic             pc_wre_raw, ir_wre_raw, reg_wre_raw, m_wr_raw;

    mc_next_state u_next_state (
        .state      (state_q),
        .opcode     (opcode),
        .state_next (state_next)
    );

    always_comb begin
        state_d       = halted_q ? S_ID : state_next;
        halted_d      = halted_q | ((state_q == S_ID) && (opcode == OP_HALT));
        illegal_d     = illegal_q | ((state_q == S_ID) && !is_known(opcode));
        instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, PCWre};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IF;
            halted_q      <= 1'b0;
            illegal_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            halted_q      <= halted_d;
            illegal_q     <= illegal_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        pc_wre_raw  = 1'b0;
        ir_wre_raw  = 1'b0;
        reg_wre_raw = 1'b0;
        m_wr_raw    = 1'b0;
        mRD         = 1'b0;
        PCSrc       = PCSRC_NEXT;
        RegDst      = REGDST_RT;
        DBDataSrc   = 1'b0;
        WrRegData   = 1'b0;
        case (state_q)
            S_IF: ir_wre_raw = 1'b1;
            S_ID: begin
                if (!halted_q && (opcode != OP_HALT) && !is_alu_instr(opcode) &&
                    (opcode != OP_BEQ) && (opcode != OP_LW) && (opcode != OP_SW)) begin
                    pc_wre_raw = 1'b1;
                    case (opcode)
                        OP_J:   PCSrc = PCSRC_JUMP;
                        OP_JR:  PCSrc = PCSRC_RS;
                        OP_JAL: begin
                            PCSrc       = PCSRC_JUMP;
                            reg_wre_raw = 1'b1;
                            RegDst      = REGDST_RA;
                        end
                        default: PCSrc = PCSRC_NEXT;
                    endcase
                end
            end
            S_WB_AL: begin
                pc_wre_raw  = 1'b1;
                reg_wre_raw = 1'b1;
                WrRegData   = 1'b1;
                RegDst      = is_rtype(opcode) ? REGDST_RD : REGDST_RT;
            end
            S_EXE_BR: begin
                pc_wre_raw = 1'b1;
                PCSrc      = zero ? PCSRC_BRANCH : PCSRC_NEXT;
            end
            S_MEM: begin
                mRD        = (opcode == OP_LW);
                m_wr_raw   = (opcode == OP_SW);
                pc_wre_raw = (opcode == OP_SW);
            end
            S_WB_LD: begin
                pc_wre_raw  = 1'b1;
                reg_wre_raw = 1'b1;
                DBDataSrc   = 1'b1;
                WrRegData   = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are suppressed during the reset cycle so no state is disturbed.
    assign PCWre   = pc_wre_raw  & ~RST;
    assign IRWre   = ir_wre_raw  & ~RST;
    assign RegWre  = reg_wre_raw & ~RST;
    assign mWR     = m_wr_raw    & ~RST;

    assign ALUSrcB = (opcode == OP_ADDI) || (opcode == OP_ORI) ||
                     (opcode == OP_LW)   || (opcode == OP_SW);
    assign ExtSel  = (opcode != OP_ORI);
    assign ALUOp   = alu_op_of(opcode);

    assign state       = state_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed self-checking bench for mc_control_unit: walks each instruction
// class through its phases with hand-computed expected control values.
module tb_mc_control_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic [5:0]  opcode;
    logic        zero;
    logic [2:0]  state;
    logic        PCWre, IRWre, RegWre, mRD, mWR;
    logic [1:0]  PCSrc, RegDst;
    logic        ALUSrcB, DBDataSrc, WrRegData, ExtSel;
    logic [2:0]  ALUOp;
    logic        halted, illegal;
    logic [15:0] instr_count;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;

    mc_control_unit #(.CNT_W(16)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .opcode      (opcode),
        .zero        (zero),
        .state       (state),
        .PCWre       (PCWre),
        .IRWre       (IRWre),
        .RegWre      (RegWre),
        .mRD         (mRD),
        .mWR         (mWR),
        .PCSrc       (PCSrc),
        .RegDst      (RegDst),
        .ALUSrcB     (ALUSrcB),
        .DBDataSrc   (DBDataSrc),
        .WrRegData   (WrRegData),
        .ExtSel      (ExtSel),
        .ALUOp       (ALUOp),
        .halted      (halted),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 CLK = ~CLK;

    task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic z);
        RST    = rst;
        opcode = op;
        zero   = z;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    localparam logic [5:0] ADD = 6'b000000, ORI = 6'b010010, SW = 6'b110000,
                           LW = 6'b110001, BEQ = 6'b110100, JR = 6'b111001,
                           JAL = 6'b111010, HALT = 6'b111111, BAD = 6'b101010;

    initial begin
        RST = 1'b1; opcode = ADD; zero = 1'b0;
        applyStimulus(1'b1, ADD, 1'b0);
        applyStimulus(1'b1, ADD, 1'b0);
        RST = 1'b0; #1;
        checkOutput("rst_state", int'(state), 0);
        checkOutput("rst_irwre", int'(IRWre), 1);
        checkOutput("rst_pcwre", int'(PCWre), 0);
        checkOutput("rst_count", int'(instr_count), 0);
        checkOutput("rst_pcsrc", int'(PCSrc), 0);
        checkOutput("rst_flags", int'({halted, illegal}), 0);

        // add: IF -> ID -> EXE_AL -> WB_AL -> IF
        applyStimulus(1'b0, ADD, 1'b0);
        checkOutput("add_id", int'(state), 1);
        checkOutput("add_id_irwre", int'(IRWre), 0);
        applyStimulus(1'b0, ADD, 1'b0);
        checkOutput("add_exe", int'(state), 6);
        checkOutput("add_exe_pcwre", int'(PCWre), 0);
        applyStimulus(1'b0, ADD, 1'b0);
        checkOutput("add_wb", int'(state), 7);
        checkOutput("add_wb_regwre", int'(RegWre), 1);
        checkOutput("add_wb_regdst", int'(RegDst), 1);
        checkOutput("add_wb_pcwre", int'(PCWre), 1);
        applyStimulus(1'b0, ADD, 1'b0);
        checkOutput("add_if", int'(state), 0);
        checkOutput("add_count", int'(instr_count), 1);

        // lw: 5 phases
        applyStimulus(1'b0, LW, 1'b0);
        applyStimulus(1'b0, LW, 1'b0);
        checkOutput("lw_exe", int'(state), 2);
        checkOutput("lw_alusrcb", int'(ALUSrcB), 1);
        applyStimulus(1'b0, LW, 1'b0);
        checkOutput("lw_mem", int'(state), 3);
        checkOutput("lw_mrd", int'(mRD), 1);
        checkOutput("lw_mem_pcwre", int'(PCWre), 0);
        applyStimulus(1'b0, LW, 1'b0);
        checkOutput("lw_wb", int'(state), 4);
        checkOutput("lw_wb_regwre", int'(RegWre), 1);
        checkOutput("lw_wb_dbsrc", int'(DBDataSrc), 1);
        checkOutput("lw_wb_pcwre", int'(PCWre), 1);
        applyStimulus(1'b0, LW, 1'b0);
        checkOutput("lw_if", int'(state), 0);
        checkOutput("lw_count", int'(instr_count), 2);

        // sw: finishes in MEM
        applyStimulus(1'b0, SW, 1'b0);
        applyStimulus(1'b0, SW, 1'b0);
        applyStimulus(1'b0, SW, 1'b0);
        checkOutput("sw_mem", int'(state), 3);
        checkOutput("sw_mwr", int'(mWR), 1);
        checkOutput("sw_mrd", int'(mRD), 0);
        checkOutput("sw_pcwre", int'(PCWre), 1);
        applyStimulus(1'b0, SW, 1'b0);
        checkOutput("sw_if", int'(state), 0);
        checkOutput("sw_count", int'(instr_count), 3);

        // beq taken and not taken
        applyStimulus(1'b0, BEQ, 1'b1);
        applyStimulus(1'b0, BEQ, 1'b1);
        checkOutput("beq1_state", int'(state), 5);
        checkOutput("beq1_pcsrc", int'(PCSrc), 1);
        checkOutput("beq1_aluop", int'(ALUOp), 1);
        checkOutput("beq1_pcwre", int'(PCWre), 1);
        applyStimulus(1'b0, BEQ, 1'b0);
        checkOutput("beq1_if", int'(state), 0);
        applyStimulus(1'b0, BEQ, 1'b0);
        applyStimulus(1'b0, BEQ, 1'b0);
        checkOutput("beq0_state", int'(state), 5);
        checkOutput("beq0_pcsrc", int'(PCSrc), 0);
        applyStimulus(1'b0, BEQ, 1'b0);
        checkOutput("beq0_if", int'(state), 0);
        checkOutput("beq_count", int'(instr_count), 5);

        // jal completes in ID
        applyStimulus(1'b0, JAL, 1'b0);
        checkOutput("jal_id", int'(state), 1);
        checkOutput("jal_regwre", int'(RegWre), 1);
        checkOutput("jal_regdst", int'(RegDst), 2);
        checkOutput("jal_pcsrc", int'(PCSrc), 3);
        checkOutput("jal_pcwre", int'(PCWre), 1);
        checkOutput("jal_wrregdata", int'(WrRegData), 0);
        applyStimulus(1'b0, JAL, 1'b0);
        checkOutput("jal_if", int'(state), 0);

        // jr
        applyStimulus(1'b0, JR, 1'b0);
        checkOutput("jr_pcsrc", int'(PCSrc), 2);
        checkOutput("jr_regwre", int'(RegWre), 0);
        applyStimulus(1'b0, JR, 1'b0);
        checkOutput("jr_if", int'(state), 0);
        checkOutput("jr_count", int'(instr_count), 7);

        // ori: I-type, zero-extended immediate
        applyStimulus(1'b0, ORI, 1'b0);
        applyStimulus(1'b0, ORI, 1'b0);
        checkOutput("ori_exe", int'(state), 6);
        checkOutput("ori_extsel", int'(ExtSel), 0);
        checkOutput("ori_alusrcb", int'(ALUSrcB), 1);
        checkOutput("ori_aluop", int'(ALUOp), 3);
        applyStimulus(1'b0, ORI, 1'b0);
        checkOutput("ori_regdst", int'(RegDst), 0);
        checkOutput("ori_regwre", int'(RegWre), 1);
        applyStimulus(1'b0, ORI, 1'b0);
        checkOutput("ori_count", int'(instr_count), 8);

        // unknown opcode acts as nop and sets illegal
        applyStimulus(1'b0, BAD, 1'b0);
        checkOutput("bad_id", int'(state), 1);
        checkOutput("bad_pcwre", int'(PCWre), 1);
        checkOutput("bad_illegal_pre", int'(illegal), 0);
        applyStimulus(1'b0, BAD, 1'b0);
        checkOutput("bad_if", int'(state), 0);
        checkOutput("bad_illegal", int'(illegal), 1);
        checkOutput("bad_count", int'(instr_count), 9);

        // halt freezes in ID
        applyStimulus(1'b0, HALT, 1'b0);
        checkOutput("halt_id", int'(state), 1);
        checkOutput("halt_pcwre", int'(PCWre), 0);
        applyStimulus(1'b0, HALT, 1'b0);
        checkOutput("halt_flag", int'(halted), 1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, HALT, 1'b0);
        checkOutput("halt_state", int'(state), 1);
        checkOutput("halt_pcwre_late", int'(PCWre), 0);
        checkOutput("halt_count", int'(instr_count), 9);

        // reset clears halt and the sticky flags
        applyStimulus(1'b1, LW, 1'b0);
        RST = 1'b0; #1;
        checkOutput("rst2_state", int'(state), 0);
        checkOutput("rst2_flags", int'({halted, illegal}), 0);
        checkOutput("rst2_count", int'(instr_count), 0);

        // reset in the MEM phase of lw
        applyStimulus(1'b0, LW, 1'b0);
        applyStimulus(1'b0, LW, 1'b0);
        applyStimulus(1'b0, LW, 1'b0);
        checkOutput("lwrst_mem", int'(state), 3);
        RST = 1'b1; #1;
        checkOutput("lwrst_pcwre", int'(PCWre), 0);
        applyStimulus(1'b1, LW, 1'b0);
        checkOutput("lwrst_state", int'(state), 0);
        checkOutput("lwrst_mrd", int'(mRD), 0);
        checkOutput("lwrst_count", int'(instr_count), 0);
        RST = 1'b0; #1;
        checkOutput("lwrst_irwre", int'(IRWre), 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
